// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode-to-execute pipeline stage:
// control word layout, opcode encodings and the immediate selector.
package pipe_pkg;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       use_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_cond;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'(10'b0);

  localparam logic [5:0] OP_LDR = 6'h20;
  localparam logic [5:0] OP_STR = 6'h21;
  localparam logic [5:0] OP_B   = 6'h30;
  localparam logic [5:0] OP_BEQ = 6'h31;
  localparam logic [5:0] OP_NOP = 6'h3F;

  // Opcode class is carried in opcode[5:4]; 0x00-0x0F and 0x10-0x1F.
  localparam logic [1:0] CLS_ALU_REG = 2'b00;
  localparam logic [1:0] CLS_ALU_IMM = 2'b01;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_Z15  = 2'd1,
    IMM_S10  = 2'd2,
    IMM_S20  = 2'd3
  } imm_sel_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/id_ex_stage_ctrl_decode.sv
// Combinational opcode decoder: control word, source-register usage,
// illegal-opcode flag and immediate format selection.
module ctrl_decode
  import pipe_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       uses_rn_o,
  output logic       uses_rm_o,
  output logic       illegal_o,
  output imm_sel_e   imm_sel_o
);

  // Opcode to control word; undefined opcodes fall back to a NOP marked illegal
  always_comb begin
    ctrl_o    = CTRL_NOP;
    uses_rn_o = 1'b0;
    uses_rm_o = 1'b0;
    illegal_o = 1'b0;
    imm_sel_o = IMM_NONE;
    if (opcode_i[5:4] == CLS_ALU_REG) begin
      ctrl_o.alu_op    = opcode_i[3:0];
      ctrl_o.reg_write = 1'b1;
      uses_rn_o        = 1'b1;
      uses_rm_o        = 1'b1;
    end else if (opcode_i[5:4] == CLS_ALU_IMM) begin
      ctrl_o.alu_op    = opcode_i[3:0];
      ctrl_o.use_imm   = 1'b1;
      ctrl_o.reg_write = 1'b1;
      uses_rn_o        = 1'b1;
      imm_sel_o        = IMM_Z15;
    end else begin
      case (opcode_i)
        OP_LDR: begin
          ctrl_o.use_imm   = 1'b1;
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.reg_write = 1'b1;
          uses_rn_o        = 1'b1;
          imm_sel_o        = IMM_S10;
        end
        OP_STR: begin
          ctrl_o.use_imm   = 1'b1;
          ctrl_o.mem_write = 1'b1;
          uses_rn_o        = 1'b1;
          uses_rm_o        = 1'b1;
          imm_sel_o        = IMM_S10;
        end
        OP_B: begin
          ctrl_o.branch = 1'b1;
          imm_sel_o     = IMM_S20;
        end
        OP_BEQ: begin
          ctrl_o.branch      = 1'b1;
          ctrl_o.branch_cond = 1'b1;
          uses_rn_o          = 1'b1;
          uses_rm_o          = 1'b1;
          imm_sel_o          = IMM_S10;
        end
        OP_NOP: begin
          ctrl_o = CTRL_NOP;
        end
        default: begin
          illegal_o = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with immediate extension, load-use hazard
// detection, branch flush, execute-busy hold and a bubble counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW  = 32,
  parameter int PCW = 16,
  parameter int RW  = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid_i,
  input  logic [PCW-1:0] id_pc_i,
  input  logic [5:0]     opcode_i,
  input  logic [RW-1:0]  rd_i,
  input  logic [RW-1:0]  rn_i,
  input  logic [RW-1:0]  rm_i,
  input  logic [9:0]     imm10_i,
  input  logic [14:0]    imm15_i,
  input  logic [19:0]    imm20_i,
  input  logic [DW-1:0]  rd1_i,
  input  logic [DW-1:0]  rd2_i,
  input  logic           ex_hold_i,
  input  logic           flush_i,
  output logic           stall_o,
  output logic           ex_valid_o,
  output logic [PCW-1:0] ex_pc_o,
  output ctrl_t          ex_ctrl_o,
  output logic [RW-1:0]  ex_rd_o,
  output logic [RW-1:0]  ex_rn_o,
  output logic [RW-1:0]  ex_rm_o,
  output logic [DW-1:0]  ex_a_o,
  output logic [DW-1:0]  ex_b_o,
  output logic [DW-1:0]  ex_imm_o,
  output logic           illegal_o,
  output logic [15:0]    bubble_cnt_o
);

  ctrl_t    dec_ctrl_s;
  logic     uses_rn_s;
  logic     uses_rm_s;
  logic     dec_illegal_s;
  imm_sel_e imm_sel_s;
  logic [DW-1:0] imm_ext_s;
  logic          lu_s;

  logic           ex_valid_q, ex_valid_d;
  logic [PCW-1:0] ex_pc_q, ex_pc_d;
  ctrl_t          ex_ctrl_q, ex_ctrl_d;
  logic [RW-1:0]  ex_rd_q, ex_rd_d;
  logic [RW-1:0]  ex_rn_q, ex_rn_d;
  logic [RW-1:0]  ex_rm_q, ex_rm_d;
  logic [DW-1:0]  ex_a_q, ex_a_d;
  logic [DW-1:0]  ex_b_q, ex_b_d;
  logic [DW-1:0]  ex_imm_q, ex_imm_d;
  logic           illegal_q, illegal_d;
  logic [15:0]    bubble_cnt_q, bubble_cnt_d;

  ctrl_decode u_ctrl_decode (
    .opcode_i  (opcode_i),
    .ctrl_o    (dec_ctrl_s),
    .uses_rn_o (uses_rn_s),
    .uses_rm_o (uses_rm_s),
    .illegal_o (dec_illegal_s),
    .imm_sel_o (imm_sel_s)
  );

  // Immediate extension selected by the decoder
  always_comb begin
    case (imm_sel_s)
      IMM_Z15: imm_ext_s = {{(DW-15){1'b0}}, imm15_i};
      IMM_S10: imm_ext_s = {{(DW-10){imm10_i[9]}}, imm10_i};
      IMM_S20: imm_ext_s = {{(DW-20){imm20_i[19]}}, imm20_i};
      default: imm_ext_s = {DW{1'b0}};
    endcase
  end

  // A load in EX whose destination the ID instruction reads needs one bubble
  always_comb begin
    lu_s = id_valid_i & ex_valid_q & ex_ctrl_q.mem_read &
           ((uses_rn_s & (rn_i == ex_rd_q)) | (uses_rm_s & (rm_i == ex_rd_q)));
  end

  // Flush kills the stall so the redirected fetch can proceed; reset forces it low
  always_comb begin
    stall_o = rst & ~flush_i & (ex_hold_i | lu_s);
  end

  // Next EX state: flush > hold > load-use bubble > normal capture
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_rd_d      = ex_rd_q;
    ex_rn_d      = ex_rn_q;
    ex_rm_d      = ex_rm_q;
    ex_a_d       = ex_a_q;
    ex_b_d       = ex_b_q;
    ex_imm_d     = ex_imm_q;
    illegal_d    = illegal_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = CTRL_NOP;
      illegal_d  = 1'b0;
    end else if (ex_hold_i) begin
      ex_valid_d = ex_valid_q;
    end else if (lu_s) begin
      ex_valid_d   = 1'b0;
      ex_ctrl_d    = CTRL_NOP;
      illegal_d    = 1'b0;
      bubble_cnt_d = sat_inc16(bubble_cnt_q);
    end else begin
      ex_valid_d = id_valid_i;
      ex_pc_d    = id_pc_i;
      ex_rd_d    = rd_i;
      ex_rn_d    = rn_i;
      ex_rm_d    = rm_i;
      ex_a_d     = rd1_i;
      ex_b_d     = rd2_i;
      ex_imm_d   = imm_ext_s;
      if (id_valid_i) begin
        ex_ctrl_d = dec_ctrl_s;
        illegal_d = dec_illegal_s;
      end else begin
        ex_ctrl_d = CTRL_NOP;
        illegal_d = 1'b0;
      end
    end
  end

  // EX pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= {PCW{1'b0}};
      ex_ctrl_q    <= CTRL_NOP;
      ex_rd_q      <= {RW{1'b0}};
      ex_rn_q      <= {RW{1'b0}};
      ex_rm_q      <= {RW{1'b0}};
      ex_a_q       <= {DW{1'b0}};
      ex_b_q       <= {DW{1'b0}};
      ex_imm_q     <= {DW{1'b0}};
      illegal_q    <= 1'b0;
      bubble_cnt_q <= 16'h0000;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rd_q      <= ex_rd_d;
      ex_rn_q      <= ex_rn_d;
      ex_rm_q      <= ex_rm_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_imm_q     <= ex_imm_d;
      illegal_q    <= illegal_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_pc_o      = ex_pc_q;
  assign ex_ctrl_o    = ex_ctrl_q;
  assign ex_rd_o      = ex_rd_q;
  assign ex_rn_o      = ex_rn_q;
  assign ex_rm_o      = ex_rm_q;
  assign ex_a_o       = ex_a_q;
  assign ex_b_o       = ex_b_q;
  assign ex_imm_o     = ex_imm_q;
  assign illegal_o    = illegal_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule
